uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It accepts words over a valid/ready handshake into an internal FIFO. It serialises each word LSB-first with configurable data width, parity and stop bits. Back-to-back frames are sent with no idle gap, and a per-frame done pulse is produced for the host-link or nonogram-result output path.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200 baud); legal values >= 2.
DATA_WIDTH, 8, data bits per frame; legal values 5..9.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits: 1 or 2.
FIFO_DEPTH, 4, input FIFO depth in words; must be a power of two >= 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
axiiv  in  1  input word valid.
axiid  in  DATA_WIDTH  input word.
axiir  out  1  ready; a word is accepted on any edge where axiiv && axiir.
axiod  out  1  serial line output; idles high.
busy  out  1  high while a frame is being shifted out.
done  out  1  one-cycle pulse after the final stop bit of each frame.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words currently queued (excludes the word being shifted).

Behaviour:
- Reset (rst=0 at an edge):
  - axiod=1, busy=0, done=0, fifo_count=0, FSM=IDLE, FIFO flushed.
  - axiir=0 while rst=0. axiir = rst && (fifo_count < FIFO_DEPTH).
- Reset mid-frame: the line returns high on the next edge, the frame is abandoned, and no done pulse is issued.
- FIFO push and pop:
  - Push on axiiv && axiir.
  - When full, axiir=0, even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves fifo_count unchanged.
  - A word pushed to an empty FIFO can be popped on the next edge. There is no same-cycle bypass.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if fifo_count>0, pop the head word into the shift register, drive axiod=0, busy=1, and go to START. Start bit time is counted from the pop edge.
  - START: lasts CLKS_PER_BIT cycles, then goes to DATA.
  - DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. The parity accumulator XORs each bit.
  - DATA exit: go to PARITY if PARITY!=0, else to STOP.
  - PARITY: the bit is the XOR of the data (even) or its inverse (odd), held CLKS_PER_BIT cycles.
  - STOP: axiod=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - STOP exit: done=1 for exactly one cycle on the edge that ends STOP.
  - STOP exit, FIFO non-empty: on that same edge pop, drive axiod=0 and go to START. busy stays 1, giving zero idle gap.
  - STOP exit, FIFO empty: busy=0 and go to IDLE.
- Latency: for a word accepted at edge E with the FIFO empty and FSM in IDLE, axiod falls at edge E+1.
- Frame length: (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, with the bit counter exact (no drift).
- The baud counter width is $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1.
- Input data is captured at push; later changes to axiid do not affect queued words.
- All outputs are registered except axiir.

Test Plan:
1. Reset and idle: CLKS_PER_BIT=4, default 8N1. Hold rst=0 for 3 cycles, then release with axiiv=0 for 100 cycles -> axiod=1, done=0, busy=0, axiir=1 after release, fifo_count=0.
2. Single frame: push 8'hAA at edge E -> axiod falls at E+1, bit sequence 0,0,1,0,1,0,1,0,1,1 with each bit 4 cycles, done pulses once at E+41, busy falls at the same time.
3. FIFO fill and back-to-back:
   - Push 8'h01,8'h02,8'h03,8'h04,8'h05 on consecutive cycles.
   - First word pops at once, next 4 fill the FIFO (fifo_count=4), axiir drops while full.
   - Five frames follow with no high gap between the stop bit and the next start bit, and exactly 5 done pulses 40 cycles apart.
4. Parity and stop modes: PARITY=2, STOP_BITS=2, DATA_WIDTH=7, push 7'h35 -> frame 0, data bits 1,0,1,0,1,1,0, parity 1 (four ones, odd), stop high for 8 cycles, total 44 cycles.
5. Push/pop collision: FIFO full, axiiv held high across the STOP->START edge -> the word is not accepted on the pop edge and is accepted the next edge. fifo_count goes 4->3->4 and no word is lost or duplicated (scoreboard check).
6. Reset mid-frame: drive rst=0 during DATA bit 3 of 8'hC3 with 2 words queued -> axiod=1 next edge, fifo_count=0, no done pulse. A post-reset push of 8'h5A transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO.
// Words arrive over a valid/ready handshake and are queued. Each word is
// sent LSB first with configurable data width, parity and stop bits.
// Frames run back to back with no idle gap. A one-cycle done pulse marks
// the end of every frame.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active low
//   axiiv      : input word valid
//   axiid      : input word [DATA_WIDTH-1:0]
//   axiir      : ready; a word is accepted when axiiv && axiir
//   axiod      : serial line, idles high
//   busy       : high while a frame is being shifted out
//   done       : one-cycle pulse after the final stop bit
//   fifo_count : words queued, not counting the word being shifted
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY != 0)
// STOP   | stop bit(s), high
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          axiiv,
    input  logic [DATA_WIDTH-1:0]         axiid,
    output logic                          axiir,
    output logic                          axiod,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_WIDTH - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    state_t                r_state;
    logic [BW-1:0]         r_baud;
    logic [NW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_axiod;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [BW-1:0]         w_baud_nxt;
    logic [NW-1:0]         w_bit_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_par_nxt;
    logic                  w_axiod_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_baud_tc;
    logic                  w_fifo_ne;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never opens a slot early.
    assign axiir     = rst && (r_count < DEPTH_C);
    assign w_push    = axiiv && axiir;
    assign w_baud_tc = (r_baud == BAUD_LAST);
    assign w_fifo_ne = (r_count != '0);

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= axiid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // ---------------- FSM: state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_axiod <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_axiod <= w_axiod_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fifo_ne) w_state_nxt = S_START;
            S_START:  if (w_baud_tc) w_state_nxt = S_DATA;
            S_DATA:   if (w_baud_tc && r_bit == DATA_LAST)
                          w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_baud_tc) w_state_nxt = S_STOP;
            S_STOP:   if (w_baud_tc && r_bit == STOP_LAST)
                          w_state_nxt = w_fifo_ne ? S_START : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs and datapath ----------------
    // The line value for the next bit is computed here and registered, so
    // axiod changes exactly on the edge that starts each bit.
    always_comb begin
        w_pop       = 1'b0;
        w_baud_nxt  = w_baud_tc ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_axiod_nxt = r_axiod;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt  = '0;
                w_axiod_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                if (w_fifo_ne) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_bit_nxt   = '0;
                    w_par_nxt   = 1'b0;
                    w_axiod_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (w_baud_tc) begin
                    w_axiod_nxt = r_shift[0];
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_baud_tc) begin
                    w_par_nxt = r_par ^ r_shift[0];
                    if (r_bit == DATA_LAST) begin
                        w_bit_nxt   = '0;
                        w_axiod_nxt = (PARITY != 0) ? (r_par ^ r_shift[0] ^ PAR_ODD) : 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_axiod_nxt = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_tc) begin
                    w_axiod_nxt = 1'b1;
                    w_bit_nxt   = '0;
                end
            end
            S_STOP: begin
                if (w_baud_tc) begin
                    if (r_bit == STOP_LAST) begin
                        w_done_nxt = 1'b1;
                        // Chain straight into the next start bit when work is queued.
                        if (w_fifo_ne) begin
                            w_pop       = 1'b1;
                            w_shift_nxt = r_mem[r_rd_ptr];
                            w_bit_nxt   = '0;
                            w_par_nxt   = 1'b0;
                            w_axiod_nxt = 1'b0;
                        end else begin
                            w_axiod_nxt = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: begin
                w_axiod_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign axiod      = r_axiod;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. dut_a is 8N1, dut_b is 7 data bits, odd parity,
// two stop bits; both use 4 clocks per bit. Inputs are driven and outputs
// sampled on the falling edge of clk.
module tb_uart_tx_fifo;

    logic       clk;
    logic       a_rst, a_axiiv, a_axiir, a_axiod, a_busy, a_done;
    logic [7:0] a_axiid;
    logic [2:0] a_count;
    logic       b_rst, b_axiiv, b_axiir, b_axiod, b_busy, b_done;
    logic [6:0] b_axiid;
    logic [2:0] b_count;

    int n_cmp;
    int n_bad;

    uart_tx_fifo #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(a_rst), .axiiv(a_axiiv), .axiid(a_axiid), .axiir(a_axiir),
        .axiod(a_axiod), .busy(a_busy), .done(a_done), .fifo_count(a_count)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_WIDTH(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(b_rst), .axiiv(b_axiiv), .axiid(b_axiid), .axiir(b_axiir),
        .axiod(b_axiod), .busy(b_busy), .done(b_done), .fifo_count(b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // {axiod,busy,done,axiir,count}
    task automatic test_reset;
        logic [6:0] obs;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {a_axiod, a_busy, a_done, a_axiir, a_count};
            n_cmp++;
            if (obs !== 7'b1_0_0_0_000) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=1000000", i, obs);
            end
        end
        a_rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            obs = {a_axiod, a_busy, a_done, a_axiir, a_count};
            n_cmp++;
            if (obs !== 7'b1_0_0_1_000) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=1001000", i, obs);
            end
        end
    endtask

    task automatic test_single_frame(input logic [7:0] d);
        logic       frame [10];
        logic [5:0] obs, exp;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[i+1] = d[i];
        frame[9] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_axiir !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ready got=%b exp=1", a_axiir);
        end
        a_axiiv = 1'b1;
        a_axiid = d;
        @(posedge clk);
        @(negedge clk);
        a_axiiv = 1'b0;
        a_axiid = ~d;
        obs = {a_axiod, a_busy, a_done, a_count};
        n_cmp++;
        if (obs !== 6'b1_0_0_001) begin
            n_bad++;
            $display("FAIL single_queued got=%b exp=100001", obs);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            obs = {a_axiod, a_busy, a_done, a_count};
            exp = {frame[(k-1)/4], 1'b1, 1'b0, 3'd0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_bit d=%h k=%0d got=%b exp=%b", d, k, obs, exp);
            end
        end
        @(negedge clk);
        obs = {a_axiod, a_busy, a_done, a_count};
        n_cmp++;
        if (obs !== 6'b1_0_1_000) begin
            n_bad++;
            $display("FAIL single_done d=%h got=%b exp=101000", d, obs);
        end
        @(negedge clk);
        obs = {a_axiod, a_busy, a_done, a_count};
        n_cmp++;
        if (obs !== 6'b1_0_0_000) begin
            n_bad++;
            $display("FAIL single_after d=%h got=%b exp=100000", d, obs);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] obs3, exp3;
        logic [3:0] obs4, exp4;
        logic [7:0] w;
        logic       eb;
        int         f, p, n_done;
        logic [2:0] exp_cnt;
        n_done = 0;
        @(negedge clk);
        a_axiiv = 1'b1;
        a_axiid = 8'h01;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_count, a_axiod} !== 4'b001_1) begin
            n_bad++;
            $display("FAIL b2b_first_push got=%b exp=0011", {a_count, a_axiod});
        end
        a_axiid = 8'h02;
        for (int t = 0; t <= 205; t++) begin
            @(negedge clk);
            f = t / 40;
            p = (t % 40) / 4;
            w = 8'(f + 1);
            if (t >= 200)    eb = 1'b1;
            else if (p == 0) eb = 1'b0;
            else if (p == 9) eb = 1'b1;
            else             eb = w[p-1];
            exp3 = {eb, (t < 200), (t > 0 && t % 40 == 0 && t <= 200)};
            obs3 = {a_axiod, a_busy, a_done};
            n_cmp++;
            if (obs3 !== exp3) begin
                n_bad++;
                $display("FAIL b2b_line t=%0d got=%b exp=%b", t, obs3, exp3);
            end
            if (a_done === 1'b1) n_done++;
            if (t <= 40) begin
                exp_cnt = (t < 3) ? 3'(t + 1) : ((t < 40) ? 3'd4 : 3'd3);
                exp4 = {exp_cnt, (exp_cnt != 3'd4)};
                obs4 = {a_count, a_axiir};
                n_cmp++;
                if (obs4 !== exp4) begin
                    n_bad++;
                    $display("FAIL b2b_fifo t=%0d got=%b exp=%b", t, obs4, exp4);
                end
            end
            if (t < 3) a_axiid = 8'(t + 3);
            if (t == 3) a_axiiv = 1'b0;
        end
        n_cmp++;
        if (n_done != 5) begin
            n_bad++;
            $display("FAIL b2b_done_count got=%0d exp=5", n_done);
        end
    endtask

    task automatic test_parity_stop;
        logic [10:0] seq;
        logic [5:0]  obs, exp;
        seq = 11'b111_0110_1010;
        @(negedge clk);
        obs = {b_axiod, b_busy, b_done, b_count};
        n_cmp++;
        if ({obs, b_axiir} !== 7'b1_0_0_000_0) begin
            n_bad++;
            $display("FAIL par_reset got=%b exp=1000000", {obs, b_axiir});
        end
        b_rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b_axiir !== 1'b1) begin
            n_bad++;
            $display("FAIL par_ready got=%b exp=1", b_axiir);
        end
        b_axiiv = 1'b1;
        b_axiid = 7'h35;
        @(posedge clk);
        @(negedge clk);
        b_axiiv = 1'b0;
        b_axiid = 7'h00;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            obs = {b_axiod, b_busy, b_done, b_count};
            exp = {seq[(k-1)/4], 1'b1, 1'b0, 3'd0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL par_bit k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        @(negedge clk);
        obs = {b_axiod, b_busy, b_done, b_count};
        n_cmp++;
        if (obs !== 6'b1_0_1_000) begin
            n_bad++;
            $display("FAIL par_done got=%b exp=101000", obs);
        end
        @(negedge clk);
        n_cmp++;
        if (b_done !== 1'b0) begin
            n_bad++;
            $display("FAIL par_done_width got=%b exp=0", b_done);
        end
    endtask

    task automatic test_collision;
        logic [7:0] sent [6];
        logic [7:0] rx_q [$];
        logic [7:0] rx_byte;
        logic [3:0] obs4, exp4;
        logic       rx_busy;
        int         rx_pos, n_done;
        for (int i = 0; i < 6; i++) sent[i] = 8'(8'h10 + i);
        rx_busy = 1'b0;
        rx_pos  = 0;
        rx_byte = 8'h00;
        n_done  = 0;
        @(negedge clk);
        a_axiiv = 1'b1;
        a_axiid = sent[0];
        @(posedge clk);
        @(negedge clk);
        a_axiid = sent[1];
        for (int t = 0; t < 250; t++) begin
            @(negedge clk);
            if (t == 3 || t == 39 || t == 40 || t == 41) begin
                exp4 = (t == 40) ? 4'b011_1 : 4'b100_0;
                obs4 = {a_count, a_axiir};
                n_cmp++;
                if (obs4 !== exp4) begin
                    n_bad++;
                    $display("FAIL coll_fifo t=%0d got=%b exp=%b", t, obs4, exp4);
                end
            end
            if (a_done === 1'b1) n_done++;
            if (!rx_busy) begin
                if (a_axiod === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_pos  = 0;
                end
            end else begin
                rx_pos++;
                if (rx_pos >= 5 && rx_pos <= 33 && rx_pos % 4 == 1)
                    rx_byte[(rx_pos-5)/4] = a_axiod;
                if (rx_pos == 37) begin
                    n_cmp++;
                    if (a_axiod !== 1'b1) begin
                        n_bad++;
                        $display("FAIL coll_stop t=%0d got=%b exp=1", t, a_axiod);
                    end
                end
                if (rx_pos == 39) begin
                    rx_busy = 1'b0;
                    rx_q.push_back(rx_byte);
                end
            end
            if (t < 3)   a_axiid = sent[t+2];
            if (t == 3)  a_axiid = sent[5];
            if (t == 41) a_axiiv = 1'b0;
        end
        n_cmp++;
        if (rx_q.size() != 6 || n_done != 6) begin
            n_bad++;
            $display("FAIL coll_frames got=%0d/%0d exp=6/6", rx_q.size(), n_done);
        end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== sent[i]) begin
                n_bad++;
                $display("FAIL coll_word i=%0d got=%h exp=%h", i, rx_q[i], sent[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [4:0] obs5;
        logic [6:0] obs7;
        @(negedge clk);
        a_axiiv = 1'b1;
        a_axiid = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        a_axiid = 8'h11;
        for (int t = 0; t <= 80; t++) begin
            @(negedge clk);
            if (t == 1) begin
                n_cmp++;
                if (a_count !== 3'd2) begin
                    n_bad++;
                    $display("FAIL rst_mid_queued got=%0d exp=2", a_count);
                end
            end
            if (t == 17) begin
                n_cmp++;
                if ({a_axiod, a_busy} !== 2'b01) begin
                    n_bad++;
                    $display("FAIL rst_mid_bit3 got=%b exp=01", {a_axiod, a_busy});
                end
            end
            if (t == 18) begin
                obs7 = {a_axiod, a_busy, a_done, a_axiir, a_count};
                n_cmp++;
                if (obs7 !== 7'b1_0_0_0_000) begin
                    n_bad++;
                    $display("FAIL rst_mid_abort got=%b exp=1000000", obs7);
                end
            end
            if (t > 18) begin
                obs5 = {a_axiod, a_busy, a_done, a_count[1:0]};
                n_cmp++;
                if (obs5 !== 5'b1_0_0_00 || a_count !== 3'd0) begin
                    n_bad++;
                    $display("FAIL rst_mid_quiet t=%0d got=%b cnt=%0d exp=10000 cnt=0", t, obs5, a_count);
                end
            end
            if (t == 0)  a_axiid = 8'h22;
            if (t == 1)  a_axiiv = 1'b0;
            if (t == 17) a_rst = 1'b0;
            if (t == 18) a_rst = 1'b1;
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        a_rst   = 1'b0;
        a_axiiv = 1'b0;
        a_axiid = 8'h00;
        b_rst   = 1'b0;
        b_axiiv = 1'b0;
        b_axiid = 7'h00;
        test_reset;
        test_single_frame(8'hAA);
        test_back_to_back;
        test_parity_stop;
        test_collision;
        test_reset_mid_frame;
        test_single_frame(8'h5A);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
